mips_alu: RTL and testbench

- 32-bit integer ALU for the single-cycle MIPS datapath. Executes shift, multiply, divide, add/sub, logic and set-less-than ops selected by a 4-bit op code.
- Primary results (r1, r2) and compare flags (eq, leq) are combinational.
- A clocked HI/LO pair captures multiply/divide results for later reads.

---
 rtl/mips_alu.sv | 161 ++++++++++++++++
 tb/tb_mips_alu.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mips_alu.sv
// mips_alu: 32-bit integer ALU for the single-cycle MIPS datapath.
//
// Purpose:
//   Executes shift, multiply, divide, add/sub, logic and set-less-than ops
//   selected by a 4-bit op code. r1/r2/eq/leq are purely combinational.
//   A clocked HI/LO pair captures multiply/divide results when hilo_en is set.
//
// Configuration macro:
//   MIPS_ALU_DIV_EN - when defined, aluop 4 performs a signed divide.
//                     When undefined, the divider is not built and aluop 4
//                     behaves like an unused code (r1 = r2 = 0, no HI/LO update).
//
// Ports:
//   clk      in   1   system clock, HI/LO update on rising edge
//   rst      in   1   synchronous active-high reset (clears HI/LO)
//   x        in  32   operand A (shift source for shift ops)
//   y        in  32   operand B (shift amount in y[4:0] for shift ops)
//   aluop    in   4   operation select
//   hilo_en  in   1   allow HI/LO capture on mul/div ops
//   r1       out 32   primary result (mul low word, div quotient)
//   r2       out 32   secondary result (mul high word, div remainder, else 0)
//   eq       out  1   x == y
//   leq      out  1   signed x <= y
//   hi       out 32   HI register
//   lo       out 32   LO register
module mips_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [3:0]  aluop,
    input  logic        hilo_en,
    output logic [31:0] r1,
    output logic [31:0] r2,
    output logic        eq,
    output logic        leq,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] OP_SLL  = 4'd0;
    localparam logic [3:0] OP_SRA  = 4'd1;
    localparam logic [3:0] OP_SRL  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_DIV  = 4'd4;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_XOR  = 4'd9;
    localparam logic [3:0] OP_NOR  = 4'd10;
    localparam logic [3:0] OP_SLT  = 4'd11;
    localparam logic [3:0] OP_SLTU = 4'd12;

    logic signed [31:0] x_s;
    logic signed [31:0] y_s;
    logic signed [63:0] x_w;
    logic signed [63:0] y_w;
    logic signed [63:0] prod;

    logic [31:0] hi_d, hi_q;
    logic [31:0] lo_d, lo_q;
    logic        capture;

    assign x_s  = x;
    assign y_s  = y;
    // Sign-extend to 64 bits so the product keeps its full signed high word.
    assign x_w  = 64'(x_s);
    assign y_w  = 64'(y_s);
    assign prod = x_w * y_w;

`ifdef MIPS_ALU_DIV_EN
    // Returns {remainder, quotient}. The two corner cases are pinned
    // explicitly so the result never depends on simulator/synth behaviour
    // for divide-by-zero or the single signed overflow case.
    function automatic logic [63:0] sdiv(input logic signed [31:0] a,
                                         input logic signed [31:0] b);
        logic signed [31:0] q;
        logic signed [31:0] r;
        if (b == 32'sd0) begin
            q = -32'sd1;
            r = a;
        end else if (a == 32'sh8000_0000 && b == -32'sd1) begin
            q = 32'sh8000_0000;
            r = 32'sd0;
        end else begin
            q = a / b;   // truncates toward zero
            r = a % b;   // sign follows the dividend
        end
        return {r, q};
    endfunction

    logic [63:0] div_res;
    assign div_res = sdiv(x_s, y_s);
`endif

    always_comb begin
        r1 = 32'd0;
        r2 = 32'd0;
        case (aluop)
            OP_SLL:  r1 = x << y[4:0];
            OP_SRA:  r1 = x_s >>> y[4:0];
            OP_SRL:  r1 = x >> y[4:0];
            OP_MUL: begin
                r1 = prod[31:0];
                r2 = prod[63:32];
            end
`ifdef MIPS_ALU_DIV_EN
            OP_DIV: begin
                r1 = div_res[31:0];
                r2 = div_res[63:32];
            end
`endif
            OP_ADD:  r1 = x + y;
            OP_SUB:  r1 = x - y;
            OP_AND:  r1 = x & y;
            OP_OR:   r1 = x | y;
            OP_XOR:  r1 = x ^ y;
            OP_NOR:  r1 = ~(x | y);
            OP_SLT:  r1 = {31'd0, (x_s < y_s)};
            OP_SLTU: r1 = {31'd0, (x < y)};
            default: begin
                r1 = 32'd0;
                r2 = 32'd0;
            end
        endcase
    end

    assign eq  = (x == y);
    assign leq = (x_s <= y_s);

`ifdef MIPS_ALU_DIV_EN
    assign capture = hilo_en && ((aluop == OP_MUL) || (aluop == OP_DIV));
`else
    assign capture = hilo_en && (aluop == OP_MUL);
`endif

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (capture) begin
            hi_d = r2;
            lo_d = r1;
        end
    end

    // HI/LO register stage; reset wins over capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_mips_alu.sv
module tb_mips_alu;

    logic        clk;
    logic        rst;
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  aluop;
    logic        hilo_en;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        eq;
    logic        leq;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec;
    int n_err;

    mips_alu dut (
        .clk     (clk),
        .rst     (rst),
        .x       (x),
        .y       (y),
        .aluop   (aluop),
        .hilo_en (hilo_en),
        .r1      (r1),
        .r2      (r2),
        .eq      (eq),
        .leq     (leq),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive a new operation on the falling edge, settle combinational outputs.
    task automatic step(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic en);
        @(negedge clk);
        aluop   = op;
        x       = a;
        y       = b;
        hilo_en = en;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b1;
        x       = 32'd0;
        y       = 32'd0;
        aluop   = 4'd0;
        hilo_en = 1'b0;

        // reset state
        tick();
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        step(4'd0, 32'd0, 32'd0, 1'b0);
        rst = 1'b0;

        // shifts
        step(4'd1, 32'hFFFF_FFF0, 32'd4, 1'b0);
        chk("sra", r1, 32'hFFFF_FFFF);
        chk("sra_r2", r2, 32'd0);
        step(4'd2, 32'hFFFF_FFF0, 32'd4, 1'b0);
        chk("srl", r1, 32'h0FFF_FFFF);
        step(4'd0, 32'hFFFF_FFF0, 32'd4, 1'b0);
        chk("sll", r1, 32'hFFFF_FF00);
        // only y[4:0] counts: 0x24 -> shift by 4
        step(4'd2, 32'h8000_0000, 32'h0000_0024, 1'b0);
        chk("srl_hiamt", r1, 32'h0800_0000);
        step(4'd1, 32'h8000_0000, 32'd31, 1'b0);
        chk("sra31", r1, 32'hFFFF_FFFF);

        // add/sub, compare
        step(4'd5, 32'h7FFF_FFFF, 32'd1, 1'b0);
        chk("add", r1, 32'h8000_0000);
        chk("add_r2", r2, 32'd0);
        step(4'd6, 32'd3, 32'd5, 1'b0);
        chk("sub", r1, 32'hFFFF_FFFE);
        step(4'd11, 32'hFFFF_FFFF, 32'd1, 1'b0);
        chk("slt", r1, 32'd1);
        step(4'd12, 32'hFFFF_FFFF, 32'd1, 1'b0);
        chk("sltu", r1, 32'd0);

        // logic ops
        step(4'd7, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0);
        chk("and", r1, 32'h00F0_1200);
        step(4'd8, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0);
        chk("or", r1, 32'hFFF0_FF34);
        step(4'd9, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0);
        chk("xor", r1, 32'hFF00_ED34);
        step(4'd10, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0);
        chk("nor", r1, 32'h000F_00CB);
        step(4'd13, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0);
        chk("op13_r1", r1, 32'd0);
        chk("op13_r2", r2, 32'd0);

        // multiply with capture
        step(4'd3, 32'hFFFF_FFFD, 32'd7, 1'b1);
        chk("mul_lo", r1, 32'hFFFF_FFEB);
        chk("mul_hi", r2, 32'hFFFF_FFFF);
        tick();
        chk("hi_mul", hi, 32'hFFFF_FFFF);
        chk("lo_mul", lo, 32'hFFFF_FFEB);

        // mul without enable must hold HI/LO
        step(4'd3, 32'h0001_0000, 32'h0001_0000, 1'b0);
        chk("mul_big_lo", r1, 32'd0);
        chk("mul_big_hi", r2, 32'd1);
        tick();
        chk("hold_hi", hi, 32'hFFFF_FFFF);
        chk("hold_lo", lo, 32'hFFFF_FFEB);

        // enabled but non-mul/div op must hold HI/LO
        step(4'd5, 32'd1, 32'd2, 1'b1);
        tick();
        chk("hold_add_lo", lo, 32'hFFFF_FFEB);

        // divide
        step(4'd4, 32'hFFFF_FFF9, 32'd2, 1'b1);
`ifdef MIPS_ALU_DIV_EN
        chk("div_q", r1, 32'hFFFF_FFFD);
        chk("div_r", r2, 32'hFFFF_FFFF);
        tick();
        chk("hi_div", hi, 32'hFFFF_FFFF);
        chk("lo_div", lo, 32'hFFFF_FFFD);
        step(4'd4, 32'd5, 32'd0, 1'b1);
        chk("div0_q", r1, 32'hFFFF_FFFF);
        chk("div0_r", r2, 32'd5);
        tick();
        chk("hi_div0", hi, 32'd5);
        chk("lo_div0", lo, 32'hFFFF_FFFF);
        step(4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("divov_q", r1, 32'h8000_0000);
        chk("divov_r", r2, 32'd0);
        step(4'd4, 32'd7, 32'hFFFF_FFFE, 1'b0);
        chk("div_neg_q", r1, 32'hFFFF_FFFD);
        chk("div_neg_r", r2, 32'd1);
`else
        chk("div_q", r1, 32'd0);
        chk("div_r", r2, 32'd0);
        tick();
        chk("hi_nodiv", hi, 32'hFFFF_FFFF);
        chk("lo_nodiv", lo, 32'hFFFF_FFEB);
        step(4'd4, 32'd5, 32'd0, 1'b1);
        chk("div0_q", r1, 32'd0);
        chk("div0_r", r2, 32'd0);
        tick();
        chk("lo_nodiv0", lo, 32'hFFFF_FFEB);
`endif

        // flags
        step(4'd5, 32'hFFFF_FFFF, 32'd0, 1'b0);
        chk("eq_ne", {31'd0, eq}, 32'd0);
        chk("leq_neg", {31'd0, leq}, 32'd1);
        step(4'd0, 32'd42, 32'd42, 1'b0);
        chk("eq_eq", {31'd0, eq}, 32'd1);
        chk("leq_eq", {31'd0, leq}, 32'd1);
        step(4'd6, 32'd1, 32'hFFFF_FFFF, 1'b0);
        chk("leq_gt", {31'd0, leq}, 32'd0);

        // reset beats capture; comb outputs still live during reset
        step(4'd3, 32'hFFFF_FFFD, 32'd7, 1'b1);
        rst = 1'b1;
        #1;
        chk("mul_in_rst", r1, 32'hFFFF_FFEB);
        tick();
        chk("rst2_hi", hi, 32'd0);
        chk("rst2_lo", lo, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
